vec_pe_sequencer: RTL and testbench
===================================

Name: vec_pe_sequencer

Overview:
- Sequences one vector processing element across a whole vector operation.
- Accepts a vector command (instr, vs1, vs2, vd, vl, SEW) and computes the number of 32-bit words to process.
- For each word, in order: reads both source words from the vector register file, issues them to the PE, waits for the PE done signal, then writes the result to vd with byte strobes.
- Sits between the coprocessor command decode and the PE / vector register file. It reports completion, or an error, through a response handshake.

Parameters:
- VLEN, 128, bits per vector register.
- WPR, VLEN/32, 32-bit words per register (derived).
- AW, 5+$clog2(WPR), register-file word address width (derived): {vreg[4:0], word_idx}.
- TIMEOUT, 16, maximum WAIT cycles for pe_done before the operation aborts with an error.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_instr  in  8  PE opcode.
- cmd_vs1  in  5  source register A.
- cmd_vs2  in  5  source register B.
- cmd_vd  in  5  destination register.
- cmd_vl  in  8  element count.
- cmd_sew  in  10  element width in bits (8, 16 or 32).
- rsp_valid  out  1  operation finished.
- rsp_ready  in  1  response accepted.
- rsp_err  out  1  error flag, valid with rsp_valid.
- busy  out  1  high when not IDLE.
- rf_ren  out  1  register-file read strobe.
- rf_raddr_a  out  AW  read address A.
- rf_raddr_b  out  AW  read address B.
- rf_rdata_a  in  32  read data A, valid the cycle after rf_ren.
- rf_rdata_b  in  32  read data B, valid the cycle after rf_ren.
- rf_wen  out  1  write strobe.
- rf_waddr  out  AW  write address.
- rf_wdata  out  32  write data.
- rf_wstrb  out  4  byte enables.
- pe_instruction  out  8  opcode to PE.
- pe_start  out  1  one-cycle issue pulse.
- pe_opA  out  32  operand A.
- pe_opB  out  32  operand B.
- pe_opC  out  32  operand C.
- pe_sew  out  10  SEW to PE.
- pe_done  in  1  PE result valid.
- pe_out  in  32  PE result.

Behaviour:
- Reset (resetn low, asynchronous): state goes to IDLE; every output register is cleared to 0; the word index and timeout counter are cleared to 0. Asserting reset in the middle of an operation aborts it with no further rf writes and no response. The first command after reset release is accepted normally.
- States: IDLE, CHECK, READ, ISSUE, WAIT, WRITE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch all cmd_* fields, clear idx, go to CHECK.
- CHECK (1 cycle):
  - bits = vl*cmd_sew, computed in 18 bits.
  - nwords = ceil(bits/32).
  - Error if any of the following; on error set err and go to RESP:
    - cmd_sew is not 8, 16 or 32;
    - cmd_instr is greater than 8'h05;
    - bits > VLEN.
  - If vl==0: go to RESP with err=0, no rf traffic.
  - Otherwise go to READ.
- READ:
  - rf_ren=1 for one cycle.
  - rf_raddr_a={vs1,idx}, rf_raddr_b={vs2,idx}.
  - Go to ISSUE.
- ISSUE:
  - Register pe_opA=rf_rdata_a, pe_opB=rf_rdata_b, pe_opC=0.
  - pe_instruction=latched instr, pe_sew=latched SEW.
  - pe_start=1 for exactly one cycle.
  - Clear the timeout counter; go to WAIT.
- WAIT:
  - pe_done is sampled starting the cycle after ISSUE. pe_done may stay high from a previous word; a high level is accepted as done.
  - On pe_done=1: latch pe_out into rf_wdata; go to WRITE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT: set err and go to RESP without writing.
  - pe_opA, pe_opB and pe_instruction stay stable throughout WAIT.
- WRITE:
  - rf_wen=1 for one cycle, rf_waddr={vd,idx}.
  - rf_wstrb=4'hF, except on the last word when rem=(bits/8) mod 4 is non-zero. In that case rf_wstrb has the low rem bits set (e.g. rem=1 → 4'h1, rem=3 → 4'h7).
  - idx++.
  - If idx+1==nwords go to RESP, else go to READ.
- RESP:
  - rsp_valid=1 and rsp_err=err, held stable until rsp_ready.
  - On rsp_ready: clear rsp_valid and err; go to IDLE.
- Throughput: 4 cycles per word (READ, ISSUE, WAIT, WRITE) when pe_done is immediate. Total latency from accept to rsp_valid is 2+4*nwords cycles.
- Strobe pulses: rf_ren, rf_wen and pe_start are never high together, and each is high for at most one cycle per word.
- Same-register operands: vd may equal vs1 or vs2. Word i is written only after word i is read, so in-place operation is legal.
- No new command is accepted while busy. cmd_valid outside IDLE is ignored.

Test Plan:
- vadd, SEW=32, vl=4, vs1 words {1,2,3,4}, vs2 words {10,20,30,40}: vd gets {11,22,33,44}, 4 writes with wstrb=F, rsp_valid at cycle 18, err=0.
- SEW=8, vl=5: nwords=2; word1 write has wstrb=4'h1; exactly 2 rf_wen pulses; word0 lanes wrap (8'hFF+8'h01=8'h00).
- Errors:
  - cmd_sew=12 → rsp_err=1, no rf_ren/rf_wen.
  - vl=5, SEW=32 with VLEN=128 → rsp_err=1.
  - cmd_instr=8'h07 → rsp_err=1.
- vl=0: rsp_valid at cycle 2, err=0, no rf traffic. Hold rsp_ready low for 5 cycles: rsp_valid and rsp_err stay stable, cmd_ready stays 0.
- pe_done tied low: after TIMEOUT cycles in WAIT, rsp_err=1 and rf_wen is never asserted. A subsequent good command completes normally.
- Reset mid-op: drop resetn during the WAIT of word 2 of 4 → all outputs 0 immediately, no later writes. A new command after release produces correct results.

Source files
------------

// File: rtl/vec_pe_sequencer.sv
// vec_pe_sequencer: walks one vector operation word by word through a
// single PE.  For each 32-bit word it reads vs1/vs2 from the register
// file, issues the pair to the PE, waits for pe_done, and then writes the
// result to vd with byte strobes.  Completion or error is reported through
// the rsp handshake.
module vec_pe_sequencer #(
    parameter int VLEN    = 128,
    parameter int WPR     = VLEN / 32,
    parameter int AW      = 5 + $clog2(WPR),
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [7:0]    cmd_instr,
    input  logic [4:0]    cmd_vs1,
    input  logic [4:0]    cmd_vs2,
    input  logic [4:0]    cmd_vd,
    input  logic [7:0]    cmd_vl,
    input  logic [9:0]    cmd_sew,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic          rsp_err,
    output logic          busy,
    output logic          rf_ren,
    output logic [AW-1:0] rf_raddr_a,
    output logic [AW-1:0] rf_raddr_b,
    input  logic [31:0]   rf_rdata_a,
    input  logic [31:0]   rf_rdata_b,
    output logic          rf_wen,
    output logic [AW-1:0] rf_waddr,
    output logic [31:0]   rf_wdata,
    output logic [3:0]    rf_wstrb,
    output logic [7:0]    pe_instruction,
    output logic          pe_start,
    output logic [31:0]   pe_opA,
    output logic [31:0]   pe_opB,
    output logic [31:0]   pe_opC,
    output logic [9:0]    pe_sew,
    input  logic          pe_done,
    input  logic [31:0]   pe_out
);

    localparam int IW = $clog2(WPR);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_READ, S_ISSUE, S_WAIT, S_WRITE, S_RESP
    } state_t;

    state_t          r_state;
    logic [7:0]      r_instr;
    logic [4:0]      r_vs1;
    logic [4:0]      r_vs2;
    logic [4:0]      r_vd;
    logic [7:0]      r_vl;
    logic [9:0]      r_sew;
    logic [IW-1:0]   r_idx;
    logic [TW-1:0]   r_tcnt;

    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic            r_rf_ren;
    logic [AW-1:0]   r_rf_raddr_a;
    logic [AW-1:0]   r_rf_raddr_b;
    logic            r_rf_wen;
    logic [AW-1:0]   r_rf_waddr;
    logic [31:0]     r_rf_wdata;
    logic [3:0]      r_rf_wstrb;
    logic [7:0]      r_pe_instruction;
    logic            r_pe_start;
    logic [31:0]     r_pe_opA;
    logic [31:0]     r_pe_opB;
    logic [9:0]      r_pe_sew;

    logic [17:0]     w_bits;
    logic [17:0]     w_nwords;
    logic            w_sew_ok;
    logic            w_err;
    logic            w_last;
    logic [IW-1:0]   w_idx_nx;
    logic [3:0]      w_wstrb;

    // Operation size and legality, derived from the latched command fields
    always_comb begin
        w_bits   = {10'd0, r_vl} * {8'd0, r_sew};
        w_nwords = (w_bits + 18'd31) >> 5;
        w_sew_ok = (r_sew == 10'd8) || (r_sew == 10'd16) || (r_sew == 10'd32);
        w_err    = !w_sew_ok || (r_instr > 8'h05) || (w_bits > 18'(VLEN));
        w_last   = ((18'(r_idx) + 18'd1) == w_nwords);
        w_idx_nx = r_idx + IW'(1);
        w_wstrb  = 4'hF;
        if (w_last) begin
            // partial last word: keep only the bytes that belong to the vector
            case (w_bits[4:3])
                2'd1:    w_wstrb = 4'h1;
                2'd2:    w_wstrb = 4'h3;
                2'd3:    w_wstrb = 4'h7;
                default: w_wstrb = 4'hF;
            endcase
        end
    end

    // Sequencer FSM; every strobe and bus is registered on entry to its state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state          <= S_IDLE;
            r_instr          <= '0;
            r_vs1            <= '0;
            r_vs2            <= '0;
            r_vd             <= '0;
            r_vl             <= '0;
            r_sew            <= '0;
            r_idx            <= '0;
            r_tcnt           <= '0;
            r_rsp_valid      <= 1'b0;
            r_rsp_err        <= 1'b0;
            r_rf_ren         <= 1'b0;
            r_rf_raddr_a     <= '0;
            r_rf_raddr_b     <= '0;
            r_rf_wen         <= 1'b0;
            r_rf_waddr       <= '0;
            r_rf_wdata       <= '0;
            r_rf_wstrb       <= '0;
            r_pe_instruction <= '0;
            r_pe_start       <= 1'b0;
            r_pe_opA         <= '0;
            r_pe_opB         <= '0;
            r_pe_sew         <= '0;
        end else begin
            r_rf_ren   <= 1'b0;
            r_rf_wen   <= 1'b0;
            r_pe_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_instr <= cmd_instr;
                        r_vs1   <= cmd_vs1;
                        r_vs2   <= cmd_vs2;
                        r_vd    <= cmd_vd;
                        r_vl    <= cmd_vl;
                        r_sew   <= cmd_sew;
                        r_idx   <= '0;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (w_err) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_vl == 8'd0) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_rf_ren     <= 1'b1;
                        r_rf_raddr_a <= {r_vs1, r_idx};
                        r_rf_raddr_b <= {r_vs2, r_idx};
                        r_state      <= S_READ;
                    end
                end
                S_READ: begin
                    r_state <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_pe_opA         <= rf_rdata_a;
                    r_pe_opB         <= rf_rdata_b;
                    r_pe_instruction <= r_instr;
                    r_pe_sew         <= r_sew;
                    r_pe_start       <= 1'b1;
                    r_tcnt           <= '0;
                    r_state          <= S_WAIT;
                end
                S_WAIT: begin
                    if (pe_done) begin
                        r_rf_wdata <= pe_out;
                        r_rf_wen   <= 1'b1;
                        r_rf_waddr <= {r_vd, r_idx};
                        r_rf_wstrb <= w_wstrb;
                        r_state    <= S_WRITE;
                    end else if (r_tcnt == TW'(TIMEOUT - 1)) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_WRITE: begin
                    r_idx <= w_idx_nx;
                    if (w_last) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_RESP;
                    end else begin
                        r_rf_ren     <= 1'b1;
                        r_rf_raddr_a <= {r_vs1, w_idx_nx};
                        r_rf_raddr_b <= {r_vs2, w_idx_nx};
                        r_state      <= S_READ;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready      = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign rsp_valid      = r_rsp_valid;
    assign rsp_err        = r_rsp_err;
    assign rf_ren         = r_rf_ren;
    assign rf_raddr_a     = r_rf_raddr_a;
    assign rf_raddr_b     = r_rf_raddr_b;
    assign rf_wen         = r_rf_wen;
    assign rf_waddr       = r_rf_waddr;
    assign rf_wdata       = r_rf_wdata;
    assign rf_wstrb       = r_rf_wstrb;
    assign pe_instruction = r_pe_instruction;
    assign pe_start       = r_pe_start;
    assign pe_opA         = r_pe_opA;
    assign pe_opB         = r_pe_opB;
    assign pe_opC         = '0;
    assign pe_sew         = r_pe_sew;

endmodule

// File: tb/tb_vec_pe_sequencer.sv
// Directed bench for vec_pe_sequencer: a behavioural register file with
// one-cycle read latency and byte-strobed writes, plus a lane-wise adder
// standing in for the PE.
module tb_vec_pe_sequencer;

    localparam int VLEN    = 128;
    localparam int AW      = 7;
    localparam int TIMEOUT = 16;

    logic          clk;
    logic          resetn;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_instr;
    logic [4:0]    cmd_vs1;
    logic [4:0]    cmd_vs2;
    logic [4:0]    cmd_vd;
    logic [7:0]    cmd_vl;
    logic [9:0]    cmd_sew;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_err;
    logic          busy;
    logic          rf_ren;
    logic [AW-1:0] rf_raddr_a;
    logic [AW-1:0] rf_raddr_b;
    logic [31:0]   rf_rdata_a;
    logic [31:0]   rf_rdata_b;
    logic          rf_wen;
    logic [AW-1:0] rf_waddr;
    logic [31:0]   rf_wdata;
    logic [3:0]    rf_wstrb;
    logic [7:0]    pe_instruction;
    logic          pe_start;
    logic [31:0]   pe_opA;
    logic [31:0]   pe_opB;
    logic [31:0]   pe_opC;
    logic [9:0]    pe_sew;
    logic          pe_done;
    logic [31:0]   pe_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [0:127];
    int ren_cnt     = 0;
    int wen_cnt     = 0;
    int start_cnt   = 0;
    int overlap_cnt = 0;
    logic [3:0] last_wstrb = '0;

    vec_pe_sequencer #(
        .VLEN    (VLEN),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk            (clk),
        .resetn         (resetn),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_instr      (cmd_instr),
        .cmd_vs1        (cmd_vs1),
        .cmd_vs2        (cmd_vs2),
        .cmd_vd         (cmd_vd),
        .cmd_vl         (cmd_vl),
        .cmd_sew        (cmd_sew),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_err        (rsp_err),
        .busy           (busy),
        .rf_ren         (rf_ren),
        .rf_raddr_a     (rf_raddr_a),
        .rf_raddr_b     (rf_raddr_b),
        .rf_rdata_a     (rf_rdata_a),
        .rf_rdata_b     (rf_rdata_b),
        .rf_wen         (rf_wen),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rf_wstrb       (rf_wstrb),
        .pe_instruction (pe_instruction),
        .pe_start       (pe_start),
        .pe_opA         (pe_opA),
        .pe_opB         (pe_opB),
        .pe_opC         (pe_opC),
        .pe_sew         (pe_sew),
        .pe_done        (pe_done),
        .pe_out         (pe_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE stand-in: element-wise add at the issued SEW
    function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b,
                                             input logic [9:0] sew);
        logic [31:0] r;
        r = '0;
        case (sew)
            10'd8:   for (int i = 0; i < 4; i++) r[8*i +: 8] = a[8*i +: 8] + b[8*i +: 8];
            10'd16:  for (int i = 0; i < 2; i++) r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
            default: r = a + b;
        endcase
        return r;
    endfunction

    assign pe_out = lane_add(pe_opA, pe_opB, pe_sew);

    // Register file model and strobe monitors
    always @(posedge clk) begin
        if (rf_ren) begin
            rf_rdata_a <= rf[rf_raddr_a];
            rf_rdata_b <= rf[rf_raddr_b];
            ren_cnt++;
        end
        if (rf_wen) begin
            for (int b = 0; b < 4; b++)
                if (rf_wstrb[b]) rf[rf_waddr][8*b +: 8] = rf_wdata[8*b +: 8];
            wen_cnt++;
            last_wstrb = rf_wstrb;
        end
        if (pe_start) start_cnt++;
        if ((rf_ren && rf_wen) || (rf_ren && pe_start) || (rf_wen && pe_start)) overlap_cnt++;
    end

    // Caller is #1 after a posedge with the DUT in IDLE; returns #1 after the accept edge
    task automatic start_cmd(input logic [7:0] instr, input logic [4:0] vs1, input logic [4:0] vs2,
                             input logic [4:0] vd, input logic [7:0] vl, input logic [9:0] sew);
        cmd_instr = instr;
        cmd_vs1   = vs1;
        cmd_vs2   = vs2;
        cmd_vd    = vd;
        cmd_vl    = vl;
        cmd_sew   = sew;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    // Cycles counted from the accept cycle (cycle 0); bounded at 100
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        pe_done   = 1'b1;
        cmd_instr = '0; cmd_vs1 = '0; cmd_vs2 = '0; cmd_vd = '0; cmd_vl = '0; cmd_sew = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rsp_valid, rsp_err, busy, rf_ren, rf_wen, pe_start, rf_wdata, pe_opA, pe_opB} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero (rsp_valid=%b busy=%b rf_ren=%b rf_wen=%b pe_start=%b) required all zero",
                     rsp_valid, busy, rf_ren, rf_wen, pe_start);
        end
        resetn = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy: got %b required 0", busy);
        end
    endtask

    task automatic test_vadd32();
        int lat, w0, r0, s0, o0;
        logic [31:0] expv [4];
        expv = '{32'd11, 32'd22, 32'd33, 32'd44};
        for (int i = 0; i < 4; i++) begin
            rf[4 + i]  = 32'(i + 1);
            rf[8 + i]  = 32'(10 * (i + 1));
            rf[12 + i] = '0;
        end
        w0 = wen_cnt; r0 = ren_cnt; s0 = start_cnt; o0 = overlap_cnt;
        start_cmd(8'h00, 5'd1, 5'd2, 5'd3, 8'd4, 10'd32);
        checks++;
        if ({busy, cmd_ready} !== 2'b10) begin
            errors++;
            $display("FAIL vadd_busy: got busy=%b cmd_ready=%b required busy=1 cmd_ready=0", busy, cmd_ready);
        end
        wait_rsp(lat);
        checks++;
        if (lat !== 18) begin
            errors++;
            $display("FAIL vadd_latency: got %0d required 18", lat);
        end
        checks++;
        if (rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL vadd_err: got %b required 0", rsp_err);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rf[12 + i] !== expv[i]) begin
                errors++;
                $display("FAIL vadd_word%0d: got %0d required %0d", i, rf[12 + i], expv[i]);
            end
        end
        checks++;
        if (wen_cnt - w0 !== 4 || ren_cnt - r0 !== 4 || start_cnt - s0 !== 4) begin
            errors++;
            $display("FAIL vadd_pulses: got wen=%0d ren=%0d start=%0d required 4 each",
                     wen_cnt - w0, ren_cnt - r0, start_cnt - s0);
        end
        checks++;
        if (overlap_cnt - o0 !== 0) begin
            errors++;
            $display("FAIL vadd_overlap: got %0d required 0", overlap_cnt - o0);
        end
        checks++;
        if (last_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL vadd_wstrb: got %h required f", last_wstrb);
        end
        ack_rsp();
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b01) begin
            errors++;
            $display("FAIL vadd_ack: got rsp_valid=%b cmd_ready=%b required 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_sew8();
        int lat, w0;
        rf[16] = 32'h01FF10FF; rf[17] = 32'h00000005;
        rf[20] = 32'h01012001; rf[21] = 32'h00000003;
        rf[24] = 32'hAAAAAAAA; rf[25] = 32'hAAAAAAAA; rf[26] = 32'hAAAAAAAA;
        w0 = wen_cnt;
        start_cmd(8'h00, 5'd4, 5'd5, 5'd6, 8'd5, 10'd8);
        wait_rsp(lat);
        checks++;
        if (lat !== 10 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL sew8_rsp: got lat=%0d err=%b required lat=10 err=0", lat, rsp_err);
        end
        checks++;
        if (wen_cnt - w0 !== 2) begin
            errors++;
            $display("FAIL sew8_wen_count: got %0d required 2", wen_cnt - w0);
        end
        checks++;
        if (last_wstrb !== 4'h1) begin
            errors++;
            $display("FAIL sew8_last_wstrb: got %h required 1", last_wstrb);
        end
        checks++;
        if (rf[24] !== 32'h02003000) begin
            errors++;
            $display("FAIL sew8_word0: got %h required 02003000", rf[24]);
        end
        checks++;
        if (rf[25] !== 32'hAAAAAA08) begin
            errors++;
            $display("FAIL sew8_word1: got %h required aaaaaa08", rf[25]);
        end
        checks++;
        if (rf[26] !== 32'hAAAAAAAA) begin
            errors++;
            $display("FAIL sew8_word2_untouched: got %h required aaaaaaaa", rf[26]);
        end
        ack_rsp();
    endtask

    task automatic test_errors();
        int lat, w0, r0;
        logic [7:0] t_instr [3];
        logic [9:0] t_sew [3];
        logic [7:0] t_vl [3];
        t_instr = '{8'h00, 8'h00, 8'h07};
        t_sew   = '{10'd12, 10'd32, 10'd32};
        t_vl    = '{8'd4, 8'd5, 8'd4};
        for (int k = 0; k < 3; k++) begin
            w0 = wen_cnt; r0 = ren_cnt;
            start_cmd(t_instr[k], 5'd1, 5'd2, 5'd13, t_vl[k], t_sew[k]);
            wait_rsp(lat);
            checks++;
            if (lat !== 2 || rsp_err !== 1'b1) begin
                errors++;
                $display("FAIL err_case%0d_rsp: got lat=%0d err=%b required lat=2 err=1", k, lat, rsp_err);
            end
            checks++;
            if (wen_cnt - w0 !== 0 || ren_cnt - r0 !== 0) begin
                errors++;
                $display("FAIL err_case%0d_rf: got ren=%0d wen=%0d required 0", k, ren_cnt - r0, wen_cnt - w0);
            end
            ack_rsp();
        end
    endtask

    task automatic test_vl_zero();
        int lat, w0, r0;
        w0 = wen_cnt; r0 = ren_cnt;
        start_cmd(8'h00, 5'd1, 5'd2, 5'd14, 8'd0, 10'd32);
        wait_rsp(lat);
        checks++;
        if (lat !== 2 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL vl0_rsp: got lat=%0d err=%b required lat=2 err=0", lat, rsp_err);
        end
        // a command offered while RESP is pending must be ignored
        cmd_vl    = 8'd4;
        cmd_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({rsp_valid, rsp_err, cmd_ready} !== 3'b100) begin
                errors++;
                $display("FAIL vl0_hold%0d: got valid=%b err=%b cmd_ready=%b required 1/0/0",
                         c, rsp_valid, rsp_err, cmd_ready);
            end
        end
        cmd_valid = 1'b0;
        checks++;
        if (wen_cnt - w0 !== 0 || ren_cnt - r0 !== 0) begin
            errors++;
            $display("FAIL vl0_rf: got ren=%0d wen=%0d required 0", ren_cnt - r0, wen_cnt - w0);
        end
        ack_rsp();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL vl0_idle: got busy=%b required 0", busy);
        end
    endtask

    task automatic test_timeout();
        int lat, w0, r0;
        pe_done = 1'b0;
        w0 = wen_cnt; r0 = ren_cnt;
        start_cmd(8'h00, 5'd1, 5'd2, 5'd15, 8'd4, 10'd32);
        wait_rsp(lat);
        checks++;
        if (lat !== 4 + TIMEOUT || rsp_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_rsp: got lat=%0d err=%b required lat=%0d err=1", lat, rsp_err, 4 + TIMEOUT);
        end
        checks++;
        if (wen_cnt - w0 !== 0 || ren_cnt - r0 !== 1) begin
            errors++;
            $display("FAIL timeout_rf: got ren=%0d wen=%0d required ren=1 wen=0", ren_cnt - r0, wen_cnt - w0);
        end
        ack_rsp();
        pe_done = 1'b1;
        // follow-up good command, SEW=16, written in place over vs1
        rf[28] = 32'h0001FFFF; rf[29] = 32'h12345678;
        rf[32] = 32'h00010001; rf[33] = 32'h11111111;
        w0 = wen_cnt;
        start_cmd(8'h01, 5'd7, 5'd8, 5'd7, 8'd4, 10'd16);
        wait_rsp(lat);
        checks++;
        if (lat !== 10 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL after_timeout_rsp: got lat=%0d err=%b required lat=10 err=0", lat, rsp_err);
        end
        checks++;
        if (rf[28] !== 32'h00020000 || rf[29] !== 32'h23456789) begin
            errors++;
            $display("FAIL after_timeout_data: got %h %h required 00020000 23456789", rf[28], rf[29]);
        end
        checks++;
        if (wen_cnt - w0 !== 2 || last_wstrb !== 4'hF) begin
            errors++;
            $display("FAIL after_timeout_wen: got wen=%0d wstrb=%h required 2 f", wen_cnt - w0, last_wstrb);
        end
        ack_rsp();
    endtask

    task automatic test_reset_midop();
        int lat, w0;
        for (int i = 0; i < 4; i++) begin
            rf[40 + i] = 32'hDEADBEEF;
            rf[36 + i] = '0;
        end
        w0 = wen_cnt;
        pe_done = 1'b1;
        start_cmd(8'h00, 5'd1, 5'd2, 5'd10, 8'd4, 10'd32);
        repeat (5) @(posedge clk);
        #1;
        pe_done = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || pe_opA !== 32'd2 || wen_cnt - w0 !== 1) begin
            errors++;
            $display("FAIL midop_state: got busy=%b opA=%0d wen=%0d required 1/2/1", busy, pe_opA, wen_cnt - w0);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, rsp_err, busy, rf_ren, rf_wen, pe_start, rf_raddr_a, rf_raddr_b, rf_waddr,
             rf_wdata, rf_wstrb, pe_instruction, pe_opA, pe_opB, pe_opC, pe_sew} !== '0) begin
            errors++;
            $display("FAIL midop_reset_outputs: got busy=%b opA=%h wdata=%h required all zero", busy, pe_opA, rf_wdata);
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL midop_reset_cmd_ready: got %b required 1", cmd_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        resetn  = 1'b1;
        pe_done = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (wen_cnt - w0 !== 1 || rf[40] !== 32'd11 || rf[41] !== 32'hDEADBEEF || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midop_abort: got wen=%0d w0=%h w1=%h rsp_valid=%b required 1/0000000b/deadbeef/0",
                     wen_cnt - w0, rf[40], rf[41], rsp_valid);
        end
        start_cmd(8'h00, 5'd1, 5'd2, 5'd9, 8'd4, 10'd32);
        wait_rsp(lat);
        checks++;
        if (lat !== 18 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL midop_rerun_rsp: got lat=%0d err=%b required lat=18 err=0", lat, rsp_err);
        end
        checks++;
        if (rf[36] !== 32'd11 || rf[37] !== 32'd22 || rf[38] !== 32'd33 || rf[39] !== 32'd44) begin
            errors++;
            $display("FAIL midop_rerun_data: got %0d %0d %0d %0d required 11 22 33 44",
                     rf[36], rf[37], rf[38], rf[39]);
        end
        ack_rsp();
    endtask

    initial begin
        test_reset();
        test_vadd32();
        test_sew8();
        test_errors();
        test_vl_zero();
        test_timeout();
        test_reset_midop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
